// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, RISC-V load/store size encodings and LSU states.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, store strobes/replication, load extract/extend.
module lsu_align #(
  parameter int unsigned XLEN = core_pkg::XLEN
) (
  input  logic            st_store_i,
  input  logic [2:0]      st_funct3_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_wdata_i,
  output logic            fault_o,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] ld_data_o
);
  import core_pkg::*;

  logic [XLEN-1:0] shifted;

  always_comb begin
    fault_o = 1'b0;
    wstrb_o = 4'b0000;
    wdata_o = st_wdata_i;
    case (st_funct3_i)
      F3_B: begin
        wstrb_o = 4'b0001 << st_off_i;
        wdata_o = {4{st_wdata_i[7:0]}};
      end
      F3_H: begin
        fault_o = st_off_i[0];
        wstrb_o = 4'b0011 << st_off_i;
        wdata_o = {2{st_wdata_i[15:0]}};
      end
      F3_W: begin
        fault_o = (st_off_i != 2'b00);
        wstrb_o = 4'b1111;
      end
      F3_BU:   fault_o = st_store_i;
      F3_HU:   fault_o = st_store_i | st_off_i[0];
      default: fault_o = 1'b1;
    endcase
    // Strobes only mean something for a legal store.
    if (!st_store_i || fault_o) begin
      wstrb_o = 4'b0000;
    end
  end

  always_comb begin
    shifted = rdata_i >> {ld_off_i, 3'b000};
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   ld_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding valid/ready data bus master with kill-on-flush.
module lsu #(
  parameter int unsigned XLEN = core_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_en,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic            op_store,
  input  logic [2:0]      op_funct3,
  input  logic [XLEN-1:0] op_addr,
  input  logic [XLEN-1:0] op_wdata,
  input  logic [4:0]      op_rd,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic            ld_valid,
  output logic [XLEN-1:0] ld_data,
  output logic [4:0]      ld_rd,
  output logic            lsu_fault
);
  import core_pkg::*;

  lsu_state_t      state_q, state_d;
  logic            kill_q, kill_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic            ld_valid_q, ld_valid_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            fault_q, fault_d;

  logic            al_fault;
  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ld_data;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_store_i  (op_store),
    .st_funct3_i (op_funct3),
    .st_off_i    (op_addr[1:0]),
    .st_wdata_i  (op_wdata),
    .fault_o     (al_fault),
    .wstrb_o     (al_wstrb),
    .wdata_o     (al_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .rdata_i     (dmem_rsp_rdata),
    .ld_data_o   (al_ld_data)
  );

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    ld_rd_d    = ld_rd_q;
    fault_d    = 1'b0;
    case (state_q)
      StIdle: begin
        kill_d = 1'b0;
        if (op_valid && lsu_en) begin
          if (al_fault) begin
            fault_d = 1'b1;
          end else begin
            state_d = StReq;
            we_d    = op_store;
            addr_d  = {op_addr[XLEN-1:2], 2'b00};
            wstrb_d = al_wstrb;
            wdata_d = al_wdata;
            f3_d    = op_funct3;
            off_d   = op_addr[1:0];
            rd_d    = op_rd;
          end
        end
      end
      StReq: begin
        if (!lsu_en) kill_d = 1'b1;
        if (dmem_req_ready) begin
          if (we_q) begin
            state_d = StIdle;
            kill_d  = 1'b0;
          end else begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (!lsu_en) kill_d = 1'b1;
        if (dmem_rsp_valid) begin
          state_d = StIdle;
          kill_d  = 1'b0;
          // A flush in the response cycle itself also suppresses writeback.
          if (!kill_q && lsu_en) begin
            ld_valid_d = 1'b1;
            ld_data_d  = al_ld_data;
            ld_rd_d    = rd_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      kill_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      ld_rd_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      ld_rd_q    <= ld_rd_d;
      fault_q    <= fault_d;
    end
  end

  assign op_ready       = (state_q == StIdle);
  assign dmem_req_valid = (state_q == StReq);
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wstrb     = wstrb_q;
  assign dmem_wdata     = wdata_q;
  assign ld_valid       = ld_valid_q;
  assign ld_data        = ld_data_q;
  assign ld_rd          = ld_rd_q;
  assign lsu_fault      = fault_q;

endmodule
